// File: rtl/serial_parallel_rx_pkg.sv
// Shared constants, state encoding and helper functions for the serial-to-parallel receiver.
package serial_parallel_rx_pkg;

  localparam int PORT_WIDTH    = 14;
  localparam int EXTRACT_LNGTH = 4;
  localparam int STATE_BW      = 1;
  localparam int CNT_W         = $clog2(PORT_WIDTH + 1);

  typedef enum logic [STATE_BW-1:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Frame lengths above the output width saturate at the output width.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [EXTRACT_LNGTH-1:0] bl);
    logic [CNT_W-1:0] len;
    if (int'(bl) > PORT_WIDTH) begin
      len = CNT_W'(PORT_WIDTH);
    end else begin
      len = CNT_W'(bl);
    end
    return len;
  endfunction

  // Ones in the low 'len' bit positions, zeros above.
  function automatic logic [PORT_WIDTH-1:0] len_mask(input logic [CNT_W-1:0] len);
    logic [PORT_WIDTH-1:0] m;
    m = {PORT_WIDTH{1'b0}};
    for (int i = 0; i < PORT_WIDTH; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/serial_parallel_rx_if.sv
// Serial input / parallel output bundle of the receiver.
interface serial_parallel_rx_if;
  import serial_parallel_rx_pkg::*;

  logic                     din;
  logic                     en;
  logic [EXTRACT_LNGTH-1:0] bit_length;
  logic [PORT_WIDTH-1:0]    dout;
  logic                     dv_out;

  // Driver side: pin logic feeding serial bits, consumer reading words.
  modport master (
    output din,
    output en,
    output bit_length,
    input  dout,
    input  dv_out
  );

  // Receiver side.
  modport slave (
    input  din,
    input  en,
    input  bit_length,
    output dout,
    output dv_out
  );

endinterface

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: LSB-first capture of a frame armed by a rising
// edge of en, with a registered word and a one-cycle valid strobe.
module serial_parallel_rx
  import serial_parallel_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  serial_parallel_rx_if.slave  bus
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [PORT_WIDTH-1:0] shift_q, shift_d;
  logic [PORT_WIDTH-1:0] dout_q, dout_d;
  logic                  dv_q, dv_d;
  logic                  en_q;

  logic                  start_s;
  logic [CNT_W-1:0]      len_sel_s;
  logic [PORT_WIDTH-1:0] din_word_s;
  logic [PORT_WIDTH-1:0] word_s;

  assign start_s    = bus.en & ~en_q;
  assign len_sel_s  = clamp_len(bus.bit_length);
  assign din_word_s = {{(PORT_WIDTH-1){1'b0}}, bus.din};
  // Bits above cnt_q are always clear in the shift register, so OR inserts the new bit.
  assign word_s     = shift_q | (din_word_s << cnt_q);

  assign bus.dout   = dout_q;
  assign bus.dv_out = dv_q;

  // Next-state, counter, shift register and output word selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s && (bus.bit_length != {EXTRACT_LNGTH{1'b0}})) begin
          len_d = len_sel_s;
          if (len_sel_s == CNT_W'(1)) begin
            // Single-bit frame finishes on its start edge.
            dout_d  = din_word_s;
            dv_d    = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            shift_d = {PORT_WIDTH{1'b0}};
          end else begin
            shift_d = din_word_s;
            cnt_d   = CNT_W'(1);
            state_d = ST_SHIFT;
          end
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {PORT_WIDTH{1'b0}};
        end
      end
      ST_SHIFT: begin
        if (bus.en) begin
          if (cnt_q == (len_q - CNT_W'(1))) begin
            dout_d  = word_s & len_mask(len_q);
            dv_d    = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            shift_d = {PORT_WIDTH{1'b0}};
            state_d = ST_IDLE;
          end else begin
            shift_d = word_s;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          // Abort: drop partial bits, keep the last completed word.
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {PORT_WIDTH{1'b0}};
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        shift_d = {PORT_WIDTH{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      shift_q <= {PORT_WIDTH{1'b0}};
      dout_q  <= {PORT_WIDTH{1'b0}};
      dv_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      en_q    <= bus.en;
    end
  end

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed self-checking bench for serial_parallel_rx.
module tb_serial_parallel_rx;
  import serial_parallel_rx_pkg::*;

  logic clk;
  logic rstn;

  int n_checks;
  int n_fail;
  int pulses;
  int pulse_at;

  serial_parallel_rx_if bus_if ();

  serial_parallel_rx dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n bits of word LSB-first, one per clock, counting dv_out pulses.
  task automatic drive_bits(input logic [15:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.din = word[i];
      tick();
      if (bus_if.dv_out === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    pulse_at = -1;
    rstn = 1'b0;
    bus_if.din = 1'b0;
    bus_if.en = 1'b0;
    bus_if.bit_length = 4'd0;

    // Reset state
    tick();
    tick();
    check("reset_dout", 32'(bus_if.dout), 32'd0);
    check("reset_dv", 32'(bus_if.dv_out), 32'd0);
    rstn = 1'b1;
    tick();

    // Nominal 8-bit frame 0x9A
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd8;
    pulses = 0;
    drive_bits(16'h009A, 8);
    check("nom_pulses", 32'(pulses), 32'd1);
    check("nom_pulse_at", 32'(pulse_at), 32'd7);
    check("nom_dout", 32'(bus_if.dout), 32'd154);
    pulses = 0;
    drive_bits(16'hFFFF, 3);
    check("nom_hold_no_restart", 32'(pulses), 32'd0);
    check("nom_hold_dout", 32'(bus_if.dout), 32'd154);
    bus_if.en = 1'b0;
    tick();

    // Max width 14 bits
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd14;
    pulses = 0;
    drive_bits(16'h2AAB, 14);
    check("max_pulses", 32'(pulses), 32'd1);
    check("max_pulse_at", 32'(pulse_at), 32'd13);
    check("max_dout", 32'(bus_if.dout), 32'h2AAB);
    bus_if.en = 1'b0;
    tick();

    // bit_length 15 clamps to 14
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd15;
    pulses = 0;
    drive_bits(16'hD234, 14);
    check("clamp_pulse_at", 32'(pulse_at), 32'd13);
    check("clamp_dout", 32'(bus_if.dout), 32'h1234);
    drive_bits(16'hFFFF, 1);
    check("clamp_pulses", 32'(pulses), 32'd1);
    bus_if.en = 1'b0;
    tick();

    // Abort: restore 154 then drop en after 4 bits
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd8;
    drive_bits(16'h009A, 8);
    bus_if.en = 1'b0;
    tick();
    bus_if.en = 1'b1;
    pulses = 0;
    drive_bits(16'h00FF, 4);
    bus_if.en = 1'b0;
    tick();
    check("abort_dv", 32'(bus_if.dv_out), 32'd0);
    drive_bits(16'hFFFF, 6);
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_dout", 32'(bus_if.dout), 32'd154);

    // Single-bit frame
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd1;
    pulses = 0;
    drive_bits(16'h0001, 1);
    check("len1_pulse_at", 32'(pulse_at), 32'd0);
    check("len1_dout", 32'(bus_if.dout), 32'd1);
    drive_bits(16'h0000, 2);
    check("len1_pulses", 32'(pulses), 32'd1);
    bus_if.en = 1'b0;
    tick();

    // Zero-length frame is ignored
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd0;
    pulses = 0;
    drive_bits(16'hFFFF, 16);
    check("len0_pulses", 32'(pulses), 32'd0);
    check("len0_dout", 32'(bus_if.dout), 32'd1);
    bus_if.en = 1'b0;
    tick();

    // Back-to-back frames, second with a mid-frame bit_length change
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd8;
    pulses = 0;
    drive_bits(16'h009A, 8);
    check("b2b_first_dout", 32'(bus_if.dout), 32'd154);
    bus_if.en = 1'b0;
    tick();
    check("b2b_gap_dv", 32'(bus_if.dv_out), 32'd0);
    bus_if.en = 1'b1;
    drive_bits(16'h003C, 1);
    bus_if.bit_length = 4'd2;
    drive_bits(16'h001E, 7);
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_second_at", 32'(pulse_at), 32'd6);
    check("b2b_second_dout", 32'(bus_if.dout), 32'd60);
    bus_if.en = 1'b0;
    tick();

    // Async reset mid-frame
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd8;
    pulses = 0;
    drive_bits(16'h00FF, 3);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_dout", 32'(bus_if.dout), 32'd0);
    check("rst_mid_dv", 32'(bus_if.dv_out), 32'd0);
    drive_bits(16'hFFFF, 6);
    bus_if.en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check("rst_mid_pulses", 32'(pulses), 32'd0);

    // Fresh frame after reset starts from IDLE
    bus_if.en = 1'b1;
    bus_if.bit_length = 4'd4;
    drive_bits(16'h0005, 4);
    check("post_rst_pulses", 32'(pulses), 32'd1);
    check("post_rst_pulse_at", 32'(pulse_at), 32'd3);
    check("post_rst_dout", 32'(bus_if.dout), 32'd5);
    bus_if.en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
